// File: rtl/avmm_reader_pkg.sv
// Shared definitions for the Avalon-MM byte reader: FSM encoding and word geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package avmm_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        UNPACK,
        DONE
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;

endpackage

// File: rtl/word_byte_unpacker.sv
// Holds one 32-bit read word and presents it little-endian, one byte per handshake.
// Latency: byte 0 is presented the cycle after load; one byte per accepted handshake.
// Backpressure: out_ready low holds the index, so out_data stays stable.
//
// Ports: clk/reset_n; load + load_data capture a word and rewind the index;
// active (from the FSM) drives out_valid; fire = accepted handshake;
// last_byte = the byte currently presented is the top byte of the word.
module word_byte_unpacker
    import avmm_reader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        active,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        fire,
    output logic        last_byte
);

    logic [31:0]           buffer;
    logic [BYTE_IDX_W-1:0] idx;

    // out_valid comes straight from the FSM state, never from out_ready.
    assign out_valid = active;
    assign fire      = active & out_ready;
    assign last_byte = (idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
    assign out_data  = buffer[{idx, 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buffer <= '0;
            idx    <= '0;
        end else if (load) begin
            buffer <= load_data;
            idx    <= '0;
        end else if (fire) begin
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/avmm_byte_reader.sv
// Single-outstanding Avalon-MM read engine that streams a memory block out as little-endian bytes.
// Latency: chipselect 1 cycle after start, first byte 2+READ_LATENCY cycles after start.
// Backpressure: out_ready low stalls in UNPACK with out_data held; no read is issued until the word drains.
//
// Ports: start/start_addr/byte_count launch a transfer (sampled in IDLE only);
// busy/done report progress; avm_* is the read-only initiator to the memory's s1 port;
// out_data/out_valid/out_ready is the byte stream.
module avmm_byte_reader #(
    parameter int ADDR_W       = 17,
    parameter int DEPTH        = 100000,
    parameter int READ_LATENCY = 1,
    parameter int LEN_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  byte_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic              avm_clken,
    input  logic [31:0]       avm_readdata,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    import avmm_reader_pkg::*;

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t             state, next_state;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   remaining;
    logic [LAT_W-1:0]   lat;

    logic               load_buf;
    logic               unpack_active;
    logic               fire;
    logic               last_byte;
    logic               final_byte;
    logic [ADDR_W-1:0]  next_addr;

    assign avm_write      = 1'b0;
    assign avm_byteenable = 4'hF;
    assign avm_clken      = 1'b1;
    assign avm_address    = addr;

    assign next_addr  = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    assign final_byte = (remaining == LEN_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        busy           = 1'b0;
        done           = 1'b0;
        avm_chipselect = 1'b0;
        unpack_active  = 1'b0;
        load_buf       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (byte_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                busy           = 1'b1;
                avm_chipselect = 1'b1;
                next_state     = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (lat == '0) begin
                    load_buf   = 1'b1;
                    next_state = UNPACK;
                end
            end
            UNPACK: begin
                busy          = 1'b1;
                unpack_active = 1'b1;
                // Count exhaustion wins over word exhaustion: a partial or
                // exactly-aligned last word never triggers another read.
                if (fire) begin
                    if (final_byte) begin
                        next_state = DONE;
                    end else if (last_byte) begin
                        next_state = ISSUE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr      <= '0;
            remaining <= '0;
            lat       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= start_addr;
                        remaining <= byte_count;
                    end
                end
                ISSUE: begin
                    lat <= LAT_W'(READ_LATENCY - 1);
                end
                WAIT: begin
                    if (lat != '0) begin
                        lat <= lat - 1'b1;
                    end
                end
                UNPACK: begin
                    if (fire) begin
                        remaining <= remaining - 1'b1;
                        if (!final_byte && last_byte) begin
                            addr <= next_addr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    word_byte_unpacker u_unpacker (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load_buf),
        .load_data (avm_readdata),
        .active    (unpack_active),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .fire      (fire),
        .last_byte (last_byte)
    );

endmodule
